// File: rtl/servo_pkg.sv
// ---------------------------------------------------------------------------
// servo_pkg
//   Shared types and limits for the arm servo sequencer and its PWM
//   generators.
//   Contents:
//     NUM_CH, PW_W               channel count and pulse-width field width
//     PW_MIN, PW_MAX, PW_RESET   legal pulse range and neutral pulse width
//     pw_t, pose_t               one pulse width / one packed pose
//     seq_state_e                sequencer FSM states
//     clamp_pw()                 saturate a requested width into the legal range
// ---------------------------------------------------------------------------
package servo_pkg;

  localparam int NUM_CH = 5;
  localparam int PW_W   = 17;

  typedef logic [PW_W-1:0] pw_t;
  // Element [i] occupies bits [i*PW_W +: PW_W] of the flat port vectors.
  typedef pw_t [NUM_CH-1:0] pose_t;

  localparam pw_t PW_MIN   = 17'd50_000;
  localparam pw_t PW_MAX   = 17'd100_000;
  localparam pw_t PW_RESET = 17'd75_000;

  typedef enum logic {
    IDLE,
    RAMP
  } seq_state_e;

  // Saturate a requested width into [PW_MIN, PW_MAX] using unsigned compares.
  function automatic pw_t clamp_pw(input pw_t w);
    if (w < PW_MIN) begin
      return PW_MIN;
    end else if (w > PW_MAX) begin
      return PW_MAX;
    end
    return w;
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// ---------------------------------------------------------------------------
// servo_frame_timer
//   Free-running servo frame counter.  Counts 0..FRAME_CYC-1 and wraps, and
//   raises frame_tick for the single cycle in which the count is FRAME_CYC-1.
//   Shared by the pose sequencer and the PWM generators so that both agree on
//   where a frame ends.
//   Parameters:
//     FRAME_CYC   clock cycles per servo frame (>= 2)
//   Ports:
//     clk         in   clock, rising edge
//     rst_n       in   asynchronous active-low reset (count returns to 0)
//     frame_tick  out  one-cycle pulse in the last cycle of every frame
// ---------------------------------------------------------------------------
module servo_frame_timer #(
  parameter int FRAME_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic frame_tick
);

  localparam int CNT_W = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYC - 1);

  logic [CNT_W-1:0] count;

  // Frame counter: wraps after the last cycle of the frame so every frame is
  // exactly FRAME_CYC cycles long.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Decoded from the registered count, so the tick is glitch-free and sits
  // exactly in the final cycle of the frame.
  assign frame_tick = (count == LAST);

endmodule

// File: rtl/servo_pose_sequencer.sv
// ---------------------------------------------------------------------------
// servo_pose_sequencer
//   Moves the arm servos from the current pose to a requested target pose.
//   A pose is taken on a valid/ready handshake, each channel is clamped to
//   [PW_MIN, PW_MAX], and the commanded widths then move toward the targets
//   once per servo frame.  pw_cur only changes in the cycle after frame_tick,
//   so the downstream PWM generators never see a mid-period change.
//
//   Build option SERVO_SLEW_EN:
//     defined   : each channel moves by at most STEP per frame.
//     undefined : the first frame_tick in RAMP jumps every channel straight to
//                 its target (STEP has no effect).
//
//   Parameters:
//     CLK_HZ, FRAME_HZ   clock and frame rates; FRAME_CYC = CLK_HZ/FRAME_HZ
//     STEP               largest per-frame change of one channel (slew build)
//   Ports:
//     clk          in   clock, rising edge
//     rst_n        in   asynchronous active-low reset
//     pose_valid   in   target pose offered
//     pose_ready   out  block can accept a pose (IDLE)
//     pose_target  in   requested widths, ch i = bits [i*PW_W +: PW_W]
//     frame_tick   out  one-cycle pulse at the end of each frame
//     pw_cur       out  current commanded widths, same packing
//     busy         out  ramp in progress
//     done         out  one-cycle pulse when every channel reached its target
//     clamp_err    out  one-cycle pulse when an accepted pose was clamped
// ---------------------------------------------------------------------------
module servo_pose_sequencer
  import servo_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int FRAME_HZ = 50,
  parameter int STEP     = 500
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pose_valid,
  output logic                   pose_ready,
  input  logic [NUM_CH*PW_W-1:0] pose_target,
  output logic                   frame_tick,
  output logic [NUM_CH*PW_W-1:0] pw_cur,
  output logic                   busy,
  output logic                   done,
  output logic                   clamp_err
);

  localparam int  FRAME_CYC = CLK_HZ / FRAME_HZ;
  localparam pw_t STEP_W    = pw_t'(STEP);

  seq_state_e state;
  pose_t      cur;
  pose_t      tgt;
  pose_t      req;
  pose_t      clamped;
  pose_t      next_cur;
  logic       any_clamp;
  logic       all_reached;
  logic       tick;

  assign req = pose_target;

  // One slew step of a single channel.  Both operands are already inside the
  // legal range, so the subtraction is taken in the direction that cannot
  // wrap and the result never overshoots the target.
  function automatic pw_t slew_step(input pw_t c, input pw_t t);
    pw_t r;
    r = c;
    if (t > c) begin
      if ((t - c) <= STEP_W) r = t;
      else                   r = c + STEP_W;
    end else if (c > t) begin
      if ((c - t) <= STEP_W) r = t;
      else                   r = c - STEP_W;
    end
    return r;
  endfunction

  servo_frame_timer #(
    .FRAME_CYC (FRAME_CYC)
  ) u_frame_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (tick)
  );

  // Per-channel combinational work: the clamped version of the offered pose,
  // whether any channel had to be clamped, the widths the next frame_tick
  // would produce, and whether that update lands every channel on target.
  always_comb begin
    clamped     = '0;
    next_cur    = '0;
    any_clamp   = 1'b0;
    all_reached = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      clamped[i] = clamp_pw(req[i]);
      if (clamped[i] != req[i]) any_clamp = 1'b1;
`ifdef SERVO_SLEW_EN
      next_cur[i] = slew_step(cur[i], tgt[i]);
`else
      next_cur[i] = tgt[i];
`endif
      if (next_cur[i] != tgt[i]) all_reached = 1'b0;
    end
  end

  // Sequencer FSM with registered outputs.  A handshake landing on a
  // frame_tick cycle is handled in IDLE, so that tick never moves pw_cur; the
  // first motion comes on the next tick seen in RAMP.  done and the return to
  // IDLE happen together, which lets a held pose be accepted in the very
  // cycle done is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur        <= {NUM_CH{PW_RESET}};
      tgt        <= {NUM_CH{PW_RESET}};
      pose_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      clamp_err  <= 1'b0;
    end else begin
      done      <= 1'b0;
      clamp_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pose_valid && pose_ready) begin
            tgt        <= clamped;
            clamp_err  <= any_clamp;
            state      <= RAMP;
            pose_ready <= 1'b0;
            busy       <= 1'b1;
          end
        end
        RAMP: begin
          if (tick) begin
            cur <= next_cur;
            if (all_reached) begin
              done       <= 1'b1;
              state      <= IDLE;
              pose_ready <= 1'b1;
              busy       <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign pw_cur     = cur;
  assign frame_tick = tick;

endmodule
